// File: rtl/ddr_wr_ctrl.sv
// ddr_wr_ctrl: grants one of four write-buffer ports and splits its request into AXI write bursts.
// Optional macro DDR_WR_TIMEOUT_EN adds a 10-bit stall watchdog that drives wr_timeout_err.
module ddr_wr_ctrl #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    ddr_clk,
    input  logic                    ddr_rst,
    input  logic                    ddr_wreq_en_1,
    input  logic                    ddr_wreq_en_2,
    input  logic                    ddr_wreq_en_3,
    input  logic                    ddr_wreq_en_4,
    input  logic                    ddr_wreq,
    input  logic [ADDR_WIDTH-1:0]   ddr_waddr,
    input  logic [LEN_WIDTH-1:0]    ddr_wr_len,
    input  logic [8*DQ_WIDTH-1:0]   ddr_wdata,
    output logic                    wr_opera_en_1,
    output logic                    wr_opera_en_2,
    output logic                    wr_opera_en_3,
    output logic                    ddr_wrdy,
    output logic                    ddr_wdone,
    output logic                    ddr_wdata_req1,
    output logic                    ddr_wdata_req2,
    output logic                    ddr_wdata_req3,
    output logic                    ddr_wdata_req4,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [8*DQ_WIDTH-1:0]   axi_wdata,
    output logic [DQ_WIDTH-1:0]     axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic                    wr_timeout_err
);
    // IDLE wait enable | GRANT wait wreq | ACCEPT size burst | AW address | W data | B response | DONE pulse wdone
    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ACCEPT, S_AW, S_W, S_B, S_DONE} state_t;
    localparam int BW = 9;

    state_t                  state_q, state_d;
    logic [3:0]              gnt_q, gnt_d;
    logic [1:0]              gnt_wait_q, gnt_wait_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic [BW-1:0]           beats_q, beats_d;
    logic                    awvalid_q, awvalid_d;
    logic [7:0]              awlen_q, awlen_d;
    logic                    wvalid_q, wvalid_d;
    logic                    wlast_q, wlast_d;
    logic                    wrdy_q, wrdy_d;
    logic                    wdone_q, wdone_d;
    logic                    aw_hs, w_hs;
    logic [LEN_WIDTH-1:0]    rem_after;
    logic [BW-1:0]           n_accept, n_next;

    function automatic logic [BW-1:0] burst_of(input logic [LEN_WIDTH-1:0] rem);
        if (rem > LEN_WIDTH'(MAX_BURST)) return BW'(MAX_BURST);
        return BW'(rem);
    endfunction

`ifdef DDR_WR_TIMEOUT_EN
    logic [9:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    assign wr_timeout_err = err_q;
`else
    assign wr_timeout_err = 1'b0;
`endif

    assign aw_hs     = awvalid_q & axi_awready;
    assign w_hs      = wvalid_q & axi_wready;
    assign rem_after = remaining_q - LEN_WIDTH'(burst_q);
    assign n_accept  = burst_of(remaining_q);
    assign n_next    = burst_of(rem_after);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_wait_d  = gnt_wait_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        beats_d     = beats_q;
        awvalid_d   = awvalid_q;
        awlen_d     = awlen_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        wrdy_d      = 1'b0;
        wdone_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ddr_wreq_en_1 | ddr_wreq_en_2 | ddr_wreq_en_3 | ddr_wreq_en_4) begin
                    state_d    = S_GRANT;
                    gnt_wait_d = 2'd3;
                    if (ddr_wreq_en_4)      gnt_d = 4'b1000;
                    else if (ddr_wreq_en_1) gnt_d = 4'b0001;
                    else if (ddr_wreq_en_2) gnt_d = 4'b0010;
                    else                    gnt_d = 4'b0100;
                end
            end
            S_GRANT: begin
                if (ddr_wreq) begin
                    addr_d      = ddr_waddr;
                    remaining_d = ddr_wr_len;
                    wrdy_d      = 1'b1;
                    state_d     = S_ACCEPT;
                end else if (gnt_wait_q == 2'd0) begin
                    gnt_d   = 4'b0000;
                    state_d = S_IDLE;
                end else begin
                    gnt_wait_d = gnt_wait_q - 2'd1;
                end
            end
            S_ACCEPT: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    burst_d   = n_accept;
                    awlen_d   = 8'(n_accept - BW'(1));
                    awvalid_d = 1'b1;
                    state_d   = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (burst_q == BW'(1));
                    beats_d   = burst_q;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    if (beats_q == BW'(1)) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        state_d  = S_B;
                    end else begin
                        beats_d = beats_q - BW'(1);
                        wlast_d = (beats_q == BW'(2));
                    end
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    // address advances 8 words per beat and wraps silently
                    addr_d      = addr_q + ADDR_WIDTH'({burst_q, 3'b000});
                    remaining_d = rem_after;
                    if (rem_after != '0) begin
                        burst_d   = n_next;
                        awlen_d   = 8'(n_next - BW'(1));
                        awvalid_d = 1'b1;
                        state_d   = S_AW;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                wdone_d = 1'b1;
                gnt_d   = 4'b0000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DDR_WR_TIMEOUT_EN
        wdog_d = 10'h3FF;
        err_d  = err_q;
        if ((state_q == S_AW && !aw_hs) || (state_q == S_W && !w_hs) || (state_q == S_B && !axi_bvalid)) begin
            if (wdog_q == 10'd1) begin
                err_d     = 1'b1;
                wdone_d   = 1'b1;
                gnt_d     = 4'b0000;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                wlast_d   = 1'b0;
                state_d   = S_IDLE;
            end else begin
                wdog_d = wdog_q - 10'd1;
            end
        end
`endif
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_wait_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beats_q     <= '0;
            awvalid_q   <= 1'b0;
            awlen_q     <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wrdy_q      <= 1'b0;
            wdone_q     <= 1'b0;
`ifdef DDR_WR_TIMEOUT_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_wait_q  <= gnt_wait_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beats_q     <= beats_d;
            awvalid_q   <= awvalid_d;
            awlen_q     <= awlen_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wrdy_q      <= wrdy_d;
            wdone_q     <= wdone_d;
`ifdef DDR_WR_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign wr_opera_en_1  = gnt_q[0];
    assign wr_opera_en_2  = gnt_q[1];
    assign wr_opera_en_3  = gnt_q[2];
    assign ddr_wrdy       = wrdy_q;
    assign ddr_wdone      = wdone_q;
    assign ddr_wdata_req1 = gnt_q[0] & w_hs;
    assign ddr_wdata_req2 = gnt_q[1] & w_hs;
    assign ddr_wdata_req3 = gnt_q[2] & w_hs;
    assign ddr_wdata_req4 = gnt_q[3] & w_hs;
    assign axi_awaddr     = addr_q;
    assign axi_awlen      = awlen_q;
    assign axi_awvalid    = awvalid_q;
    assign axi_wdata      = ddr_wdata;
    assign axi_wstrb      = '1;
    assign axi_wlast      = wlast_q;
    assign axi_wvalid     = wvalid_q;
    assign axi_bready     = 1'b1;
endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Directed bench for ddr_wr_ctrl: expected AW bursts are queued from a small model and popped on each AW handshake.
module tb_ddr_wr_ctrl;
    localparam int AW = 27;
    localparam int LW = 16;
    localparam int DQ = 32;

    logic            ddr_clk = 1'b0;
    logic            ddr_rst;
    logic            ddr_wreq_en_1, ddr_wreq_en_2, ddr_wreq_en_3, ddr_wreq_en_4;
    logic            ddr_wreq;
    logic [AW-1:0]   ddr_waddr;
    logic [LW-1:0]   ddr_wr_len;
    logic [8*DQ-1:0] ddr_wdata;
    logic            wr_opera_en_1, wr_opera_en_2, wr_opera_en_3;
    logic            ddr_wrdy, ddr_wdone;
    logic            ddr_wdata_req1, ddr_wdata_req2, ddr_wdata_req3, ddr_wdata_req4;
    logic [AW-1:0]   axi_awaddr;
    logic [7:0]      axi_awlen;
    logic            axi_awvalid, axi_awready;
    logic [8*DQ-1:0] axi_wdata;
    logic [DQ-1:0]   axi_wstrb;
    logic            axi_wlast, axi_wvalid, axi_wready;
    logic            axi_bvalid, axi_bready;
    logic            wr_timeout_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;
    aw_t aw_q[$];

    int vectors = 0;
    int miscompares = 0;

    wire [2:0] gnt_v = {wr_opera_en_3, wr_opera_en_2, wr_opera_en_1};
    wire [3:0] req_v = {ddr_wdata_req4, ddr_wdata_req3, ddr_wdata_req2, ddr_wdata_req1};

    always #5 ddr_clk = ~ddr_clk;

    ddr_wr_ctrl dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .ddr_wreq_en_1(ddr_wreq_en_1), .ddr_wreq_en_2(ddr_wreq_en_2),
        .ddr_wreq_en_3(ddr_wreq_en_3), .ddr_wreq_en_4(ddr_wreq_en_4),
        .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len), .ddr_wdata(ddr_wdata),
        .wr_opera_en_1(wr_opera_en_1), .wr_opera_en_2(wr_opera_en_2), .wr_opera_en_3(wr_opera_en_3),
        .ddr_wrdy(ddr_wrdy), .ddr_wdone(ddr_wdone),
        .ddr_wdata_req1(ddr_wdata_req1), .ddr_wdata_req2(ddr_wdata_req2),
        .ddr_wdata_req3(ddr_wdata_req3), .ddr_wdata_req4(ddr_wdata_req4),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .wr_timeout_err(wr_timeout_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs driven after a sample take effect at the next rising edge
    task automatic cyc();
        @(negedge ddr_clk);
        #1;
    endtask

    task automatic serve(input logic [3:0] en, input int port, input logic [AW-1:0] addr, input int len,
                         input bit rnd, input logic [3:0] busy_en, input int rst_beat);
        logic [AW-1:0]   a;
        int              rem, n, beat, total;
        bit              bpend, done;
        logic [2:0]      exp_gnt;
        logic [3:0]      exp_req;
        logic [8*DQ-1:0] wd;
        aw_t             e;
        exp_gnt = (port == 4) ? 3'b000 : 3'(1 << (port - 1));
        exp_req = 4'(1 << (port - 1));
        aw_q.delete();
        a = addr;
        rem = len;
        while (rem > 0) begin
            n = (rem > 16) ? 16 : rem;
            aw_q.push_back({a, 8'(n - 1)});
            a = a + AW'(n * 8);
            rem -= n;
        end
        {ddr_wreq_en_4, ddr_wreq_en_3, ddr_wreq_en_2, ddr_wreq_en_1} = en;
        cyc();
        check("grant", gnt_v, exp_gnt);
        {ddr_wreq_en_4, ddr_wreq_en_3, ddr_wreq_en_2, ddr_wreq_en_1} = busy_en;
        ddr_wreq = 1'b1;
        ddr_waddr = addr;
        ddr_wr_len = LW'(len);
        cyc();
        check("wrdy", ddr_wrdy, 1'b1);
        ddr_wreq = 1'b0;
        n = 0; beat = 0; total = 0; bpend = 0; done = 0;
        for (int c = 0; c < 800 && !done; c++) begin
            @(negedge ddr_clk);
            axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_bvalid  = bpend;
            bpend = 0;
            for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
            ddr_wdata = wd;
            #1;
            check("aw_w_excl", axi_awvalid & axi_wvalid, 1'b0);
            check("wdata_req", req_v, (axi_wvalid & axi_wready) ? exp_req : 4'b0000);
            if (ddr_wdone) begin
                done = 1;
                check("grant_drop", gnt_v, 3'b000);
            end else begin
                check("grant_hold", gnt_v, exp_gnt);
            end
            if (axi_awvalid && axi_awready) begin
                if (aw_q.size() == 0) begin
                    check("aw_extra", axi_awvalid, 1'b0);
                end else begin
                    e = aw_q.pop_front();
                    check("awaddr", axi_awaddr, e.addr);
                    check("awlen", axi_awlen, e.len);
                    n = int'(e.len) + 1;
                    beat = 0;
                end
            end
            if (axi_wvalid && axi_wready) begin
                beat++;
                total++;
                check("wlast", axi_wlast, beat == n);
                check("wdata", axi_wdata, wd);
                if (beat == n) bpend = 1;
                if (total == rst_beat) begin
                    ddr_rst = 1'b1;
                    break;
                end
            end
        end
        axi_bvalid = 1'b0;
        {ddr_wreq_en_4, ddr_wreq_en_3, ddr_wreq_en_2, ddr_wreq_en_1} = 4'b0000;
        if (rst_beat > 0) begin
            cyc();
            check("rst_awvalid", axi_awvalid, 1'b0);
            check("rst_wvalid", axi_wvalid, 1'b0);
            check("rst_wlast", axi_wlast, 1'b0);
            check("rst_grant", gnt_v, 3'b000);
            check("rst_awaddr", axi_awaddr, '0);
            check("rst_wdone", ddr_wdone, 1'b0);
            check("rst_beats", total, rst_beat);
            ddr_rst = 1'b0;
            repeat (4) begin
                cyc();
                check("rst_no_wdone", ddr_wdone, 1'b0);
                check("rst_idle_awvalid", axi_awvalid, 1'b0);
            end
        end else begin
            check("wdone_seen", done, 1'b1);
            check("bursts_left", aw_q.size(), 0);
            check("beats", total, len);
            cyc();
            check("wdone_pulse", ddr_wdone, 1'b0);
        end
    endtask

    initial begin
        ddr_rst = 1'b1;
        {ddr_wreq_en_4, ddr_wreq_en_3, ddr_wreq_en_2, ddr_wreq_en_1} = 4'b0000;
        ddr_wreq = 1'b0;
        ddr_waddr = '0;
        ddr_wr_len = '0;
        ddr_wdata = '0;
        axi_awready = 1'b1;
        axi_wready = 1'b1;
        axi_bvalid = 1'b0;
        repeat (3) cyc();
        check("rst_gnt", gnt_v, 3'b000);
        check("rst_wrdy", ddr_wrdy, 1'b0);
        check("rst_wdone0", ddr_wdone, 1'b0);
        check("rst_req", req_v, 4'b0000);
        check("rst_awv", axi_awvalid, 1'b0);
        check("rst_wv", axi_wvalid, 1'b0);
        check("rst_awlen", axi_awlen, 8'h00);
        check("rst_bready", axi_bready, 1'b1);
        check("rst_wstrb", axi_wstrb, 32'hFFFF_FFFF);
        check("rst_err", wr_timeout_err, 1'b0);
        ddr_rst = 1'b0;
        cyc();

        serve(4'b0001, 1, 27'h100, 16, 0, 4'b0000, 0);
        serve(4'b0010, 2, 27'h2000, 40, 1, 4'b1000, 0);
        serve(4'b1001, 4, 27'h40, 5, 0, 4'b0000, 0);
        serve(4'b0110, 2, 27'h300, 1, 0, 4'b0000, 0);
        serve(4'b0100, 3, 27'h7FF_FFF8, 20, 1, 4'b0000, 0);

        // zero-length request: wrdy, then wdone two cycles later with no AW
        ddr_wreq_en_1 = 1'b1;
        cyc();
        check("l0_grant", gnt_v, 3'b001);
        ddr_wreq_en_1 = 1'b0;
        ddr_wreq = 1'b1;
        ddr_waddr = 27'h700;
        ddr_wr_len = '0;
        cyc();
        check("l0_wrdy", ddr_wrdy, 1'b1);
        ddr_wreq = 1'b0;
        cyc();
        check("l0_wdone_early", ddr_wdone, 1'b0);
        check("l0_awvalid_a", axi_awvalid, 1'b0);
        cyc();
        check("l0_wdone", ddr_wdone, 1'b1);
        check("l0_awvalid_b", axi_awvalid, 1'b0);
        cyc();
        check("l0_wdone_end", ddr_wdone, 1'b0);

        // grant lost: no wreq for four cycles returns to IDLE silently
        ddr_wreq_en_2 = 1'b1;
        cyc();
        check("gl_grant", gnt_v, 3'b010);
        ddr_wreq_en_2 = 1'b0;
        repeat (3) begin
            cyc();
            check("gl_hold", gnt_v, 3'b010);
            check("gl_wrdy", ddr_wrdy, 1'b0);
        end
        cyc();
        check("gl_drop", gnt_v, 3'b000);
        check("gl_wdone", ddr_wdone, 1'b0);

        serve(4'b0001, 1, 27'h500, 16, 0, 4'b0000, 5);
        serve(4'b0100, 3, 27'h600, 3, 0, 4'b0000, 0);

`ifdef DDR_WR_TIMEOUT_EN
        begin : tmo
            int w0;
            bit hit;
            w0 = -1;
            hit = 0;
            ddr_wreq_en_3 = 1'b1;
            cyc();
            ddr_wreq_en_3 = 1'b0;
            axi_wready = 1'b0;
            ddr_wreq = 1'b1;
            ddr_waddr = 27'h900;
            ddr_wr_len = 16'd4;
            cyc();
            ddr_wreq = 1'b0;
            for (int c = 0; c < 1200 && !hit; c++) begin
                cyc();
                if (axi_wvalid && w0 < 0) w0 = c;
                if (ddr_wdone) begin
                    hit = 1;
                    check("tmo_delay", c - w0, 1023);
                    check("tmo_err", wr_timeout_err, 1'b1);
                end
            end
            check("tmo_seen", hit, 1'b1);
            cyc();
            check("tmo_sticky", wr_timeout_err, 1'b1);
            check("tmo_wvalid", axi_wvalid, 1'b0);
            axi_wready = 1'b1;
            ddr_rst = 1'b1;
            cyc();
            check("tmo_rst_clear", wr_timeout_err, 1'b0);
            ddr_rst = 1'b0;
            cyc();
        end
`else
        check("no_tmo", wr_timeout_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ddr_wr_ctrl.md
DDR_WR_CTRL -- requirements
Module: ddr_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 27: width of the DDR word address.
REQ-002 Parameter LEN_WIDTH, default 16: width of the request length, counted in 8*DQ_WIDTH beats.
REQ-003 Parameter DQ_WIDTH, default 32: DDR DQ width; one beat is 8*DQ_WIDTH bits.
REQ-004 Parameter MAX_BURST, default 16: maximum number of AXI beats per burst, range 1..256.
REQ-005 Clock and reset: one clock, ddr_clk; reset is synchronous and active-high, port ddr_rst.
REQ-006 ddr_clk  in  1  sole clock; every register samples on its rising edge.
REQ-007 ddr_rst  in  1  synchronous, active-high reset.
REQ-008 ddr_wreq_en_1..4  in  1 each  per-port request enables from the write buffer.
REQ-009 ddr_wreq  in  1  muxed request from the granted port.
REQ-010 ddr_waddr  in  ADDR_WIDTH  start address of the request.
REQ-011 ddr_wr_len  in  LEN_WIDTH  number of beats in the request.
REQ-012 ddr_wdata  in  8*DQ_WIDTH  show-ahead write data from the granted port.
REQ-013 wr_opera_en_1..3  out  1 each  one-hot grant that selects the upstream mux; all three low means port 4.
REQ-014 ddr_wrdy  out  1  one-cycle pulse: request accepted.
REQ-015 ddr_wdone  out  1  one-cycle pulse: request complete.
REQ-016 ddr_wdata_req1..4  out  1 each  one-cycle data pop to the granted port.
REQ-017 axi_awaddr  out  ADDR_WIDTH; axi_awlen  out  8; axi_awvalid  out  1; axi_awready  in  1.
REQ-018 axi_wdata  out  8*DQ_WIDTH; axi_wstrb  out  DQ_WIDTH (all ones); axi_wlast  out  1; axi_wvalid  out  1; axi_wready  in  1.
REQ-019 axi_bvalid  in  1; axi_bready  out  1 (tied 1).
REQ-020 wr_timeout_err  out  1  sticky watchdog flag.

Function
REQ-021 The FSM SHALL have states IDLE, GRANT, ACCEPT, AW, W, B and DONE.
REQ-022 In IDLE, any enable high SHALL move to GRANT and latch the grant one-hot; priority is 4 > 1 > 2 > 3.
- wr_opera_en_x stays registered and stable from GRANT through DONE.
REQ-023 In GRANT, when ddr_wreq = 1:
- latch ddr_waddr and ddr_wr_len;
- pulse ddr_wrdy for exactly one cycle;
- go to ACCEPT.
REQ-024 In GRANT, if the grant is lost (ddr_wreq = 0 for 4 cycles), SHALL return to IDLE without a pulse.
REQ-025 In ACCEPT:
- ddr_wr_len = 0 SHALL go directly to DONE;
- otherwise compute n = min(remaining, MAX_BURST) and go to AW.
REQ-026 In AW, the block SHALL hold axi_awvalid = 1, axi_awaddr = current address, and axi_awlen = n-1 until axi_awready; then go to W.
REQ-027 In W:
- axi_wvalid = 1 and axi_wdata = ddr_wdata (combinational pass-through);
- ddr_wdata_req of the granted port = axi_wvalid & axi_wready;
- axi_wlast is high on beat n.
REQ-028 After the last beat, SHALL go to B.
REQ-029 On axi_bvalid, SHALL update address += n*8 and remaining -= n.
- If remaining > 0, go to AW (next burst); else go to DONE.
REQ-030 Remaining-count and address arithmetic is unsigned; the address wraps modulo 2^ADDR_WIDTH without error.
REQ-031 DONE SHALL pulse ddr_wdone for one cycle, drop all grants, and return to IDLE.
REQ-032 Latency from ddr_wreq to ddr_wrdy SHALL be 1 cycle.
REQ-033 Enables that change while busy SHALL be ignored until IDLE.
REQ-034 axi_awvalid and axi_wvalid SHALL never be high simultaneously.

Reset
REQ-035 On ddr_rst = 1, the block SHALL:
- enter IDLE;
- drive all outputs to 0 except axi_bready = 1 and axi_wstrb = all ones;
- clear the counters and wr_timeout_err.
REQ-036 A reset mid-burst SHALL abort immediately with no ddr_wdone pulse.

Configuration
REQ-037 Macro DDR_WR_TIMEOUT_EN.
- Defined: a 10-bit watchdog counts cycles in AW, W or B without handshake progress. At 1023 it SHALL set wr_timeout_err, pulse ddr_wdone, and go to IDLE.
- Undefined: no watchdog; wr_timeout_err is constant 0.

Verification
REQ-038 en_1 = 1, ddr_waddr = 0x100, len = 16, ready always 1 -> wr_opera_en_1 high; one AW with awlen = 15 and awaddr = 0x100; 16 beats, wlast on beat 16; 16 ddr_wdata_req1 pulses; one ddr_wdone.
REQ-039 en_2 = 1, len = 40, MAX_BURST = 16 -> bursts awlen 15, 15, 7 at addresses base, base+128, base+256; ddr_wdone after the third bvalid.
REQ-040 en_4 and en_1 high together -> port 4 served; all wr_opera_en low; ddr_wdata_req4 pulses.
REQ-041 len = 0 -> ddr_wrdy, then ddr_wdone two cycles later; no axi_awvalid.
REQ-042 ddr_rst asserted at beat 5 of 16 -> next cycle all valids low and state IDLE; no ddr_wdone.
REQ-043 DDR_WR_TIMEOUT_EN defined, axi_wready held 0 -> wr_timeout_err = 1 and ddr_wdone pulse after 1023 stalled cycles.
